// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic DEPTH-stage register pipeline with valid/ready handshakes, flush and occupancy count.
// Latency: a word accepted at edge N is on DOut after edge N+DEPTH-1; sustains 1 word/cycle, even when full.
// Backpressure: out_ready=0 stalls the last stage; the stall ripples back through every stage to in_ready.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   flush               synchronous clear of all stage valid bits (data regs keep their contents)
//   in_valid/in_ready   source handshake, DIn is captured into stage 0 when both are high
//   out_valid/out_ready sink handshake, DOut is the last stage data register
//   count               registered number of occupied stages, 0..DEPTH
module pipe_reg_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             DIn,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             DOut,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] adv;      // word in stage k leaves it at the next edge
    logic [DEPTH-1:0] load;     // stage k captures a new word at the next edge
    logic             ripple;
    logic             push;
    logic             pop;

    // Advance chain, computed from the output stage backwards. A stage may
    // move when the stage ahead is empty or is itself moving this cycle, so a
    // full pipeline still accepts a word on the same cycle one leaves.
    always_comb begin
        adv          = '0;
        ripple       = valid[DEPTH-1] & out_ready & ~flush;
        adv[DEPTH-1] = ripple;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            ripple = valid[k] & (~valid[k+1] | ripple);
            adv[k] = ripple;
        end
    end

    assign in_ready  = ~flush & (~valid[0] | adv[0]);
    assign out_valid = valid[DEPTH-1] & ~flush;
    assign DOut      = data[DEPTH-1];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Inner stages can still see adv high during a flush; gating here keeps
    // the data registers untouched while the valid bits are cleared.
    always_comb begin
        load    = '0;
        load[0] = push;
        for (int k = 1; k < DEPTH; k++) begin
            load[k] = adv[k-1] & ~flush;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (load[k]) begin
                    valid[k] <= 1'b1;
                end else if (adv[k]) begin
                    valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                data[0] <= DIn;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (load[k]) begin
                    data[k] <= data[k-1];
                end
            end
        end
    end

    // Occupancy tracks handshakes rather than summing valid bits, so it is a
    // plain up/down counter with no adder tree.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push & ~pop) begin
            count <= count + CW'(1);
        end else if (pop & ~push) begin
            count <= count - CW'(1);
        end
    end

endmodule
